// File: rtl/list_pkg.sv
// Shared types and helpers for the list feeder and its adder-side users.
package list_pkg;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    SUM    = 2'd1,
    RESULT = 2'd2
  } state_e;

  // Width of a sum over n elements of w bits each, so no carry is ever lost.
  function automatic int result_width(input int n, input int w);
    return $clog2(n) + w;
  endfunction

endpackage

// File: rtl/list_feeder_if.sv
// Element-in and result-out handshakes of the list feeder.
interface list_feeder_if
  import list_pkg::*;
#(
  parameter  int DATA_WIDTH   = 32,
  parameter  int LENGTH       = 8,
  localparam int RESULT_WIDTH = result_width(LENGTH, DATA_WIDTH)
);

  logic                    in_valid;
  logic [DATA_WIDTH-1:0]   in_data;
  logic                    in_last;
  logic                    in_ready;
  logic                    res_valid;
  logic [RESULT_WIDTH-1:0] res_data;
  logic                    res_ready;

  modport master (
    output in_valid, in_data, in_last, res_ready,
    input  in_ready, res_valid, res_data
  );

  modport slave (
    input  in_valid, in_data, in_last, res_ready,
    output in_ready, res_valid, res_data
  );

endinterface

// File: rtl/list_feeder.sv
// Front end for the list adder: gathers elements into a packed list, runs the
// adder with sum_en until sum_done, then hands the sum out on a result port.
module list_feeder
  import list_pkg::*;
#(
  parameter  int DATA_WIDTH   = 32,
  parameter  int LENGTH       = 8,
  localparam int RESULT_WIDTH = result_width(LENGTH, DATA_WIDTH),
  localparam int CNT_WIDTH    = $clog2(LENGTH + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  list_feeder_if.slave                 io,
  output logic [LENGTH*DATA_WIDTH-1:0] list_data,
  output logic                         sum_en,
  input  logic                         sum_done,
  input  logic [RESULT_WIDTH-1:0]      sum_result,
  output logic [CNT_WIDTH-1:0]         elem_count
);

  state_e                        state_q, state_d;
  logic [LENGTH*DATA_WIDTH-1:0]  list_q, list_d;
  logic [CNT_WIDTH-1:0]          elem_count_q, elem_count_d;
  logic                          sum_en_q, sum_en_d;
  logic                          res_valid_q, res_valid_d;
  logic [RESULT_WIDTH-1:0]       res_data_q, res_data_d;
  logic                          in_ready_w;

  // Held low while rst is asserted so nothing is offered during reset.
  assign in_ready_w = (state_q == LOAD) && !rst;

  always_comb begin
    state_d      = state_q;
    list_d       = list_q;
    elem_count_d = elem_count_q;
    sum_en_d     = sum_en_q;
    res_valid_d  = res_valid_q;
    res_data_d   = res_data_q;

    case (state_q)
      LOAD: begin
        if (io.in_valid && in_ready_w) begin
          for (int k = 0; k < LENGTH; k++) begin
            if (elem_count_q == CNT_WIDTH'(k)) begin
              list_d[k*DATA_WIDTH +: DATA_WIDTH] = io.in_data;
            end
          end
          elem_count_d = elem_count_q + CNT_WIDTH'(1);
          if (io.in_last || (elem_count_q == CNT_WIDTH'(LENGTH - 1))) begin
            sum_en_d = 1'b1;
            state_d  = SUM;
          end
        end
      end

      SUM: begin
        if (sum_done) begin
          res_data_d  = sum_result;
          res_valid_d = 1'b1;
          sum_en_d    = 1'b0;
          state_d     = RESULT;
        end
      end

      RESULT: begin
        // sum_en stays low here, so the adder always sees a gap between lists.
        if (io.res_ready) begin
          res_valid_d  = 1'b0;
          list_d       = '0;
          elem_count_d = '0;
          state_d      = LOAD;
        end
      end

      default: begin
        state_d = LOAD;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= LOAD;
      list_q       <= '0;
      elem_count_q <= '0;
      sum_en_q     <= 1'b0;
      res_valid_q  <= 1'b0;
      res_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      list_q       <= list_d;
      elem_count_q <= elem_count_d;
      sum_en_q     <= sum_en_d;
      res_valid_q  <= res_valid_d;
      res_data_q   <= res_data_d;
    end
  end

  assign io.in_ready  = in_ready_w;
  assign io.res_valid = res_valid_q;
  assign io.res_data  = res_data_q;
  assign list_data    = list_q;
  assign sum_en       = sum_en_q;
  assign elem_count   = elem_count_q;

endmodule

// File: tb/tb_list_feeder.sv
// Bench for list_feeder with a behavioural adder (combinational or 4-cycle).
module tb_list_feeder;
  import list_pkg::*;

  localparam int DW = 8;
  localparam int LEN = 4;
  localparam int RW = result_width(LEN, DW);
  localparam int CW = $clog2(LEN + 1);

  logic              clk;
  logic              rst;
  logic [LEN*DW-1:0] list_data;
  logic              sum_en;
  logic              sum_done;
  logic [RW-1:0]     sum_result;
  logic [CW-1:0]     elem_count;

  list_feeder_if #(.DATA_WIDTH(DW), .LENGTH(LEN)) bus ();

  list_feeder #(.DATA_WIDTH(DW), .LENGTH(LEN)) dut (
    .clk        (clk),
    .rst        (rst),
    .io         (bus.slave),
    .list_data  (list_data),
    .sum_en     (sum_en),
    .sum_done   (sum_done),
    .sum_result (sum_result),
    .elem_count (elem_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Adder stand-in: combinational (done with sum_en) or done on the 4th sum_en cycle.
  logic          seq_mode;
  logic          done_inject;
  logic [2:0]    acnt;
  logic          adder_done;
  logic [RW-1:0] adder_sum;

  always_ff @(posedge clk) begin
    if (!sum_en) acnt <= 3'd0;
    else if (acnt != 3'd3) acnt <= acnt + 3'd1;
  end

  always_comb begin
    adder_sum = '0;
    for (int k = 0; k < LEN; k++) adder_sum = adder_sum + RW'(list_data[k*DW +: DW]);
    adder_done = seq_mode ? (sum_en && acnt == 3'd3) : sum_en;
    sum_done   = adder_done | done_inject;
    sum_result = adder_done ? adder_sum : '0;
  end

  int            checks = 0;
  int            errors = 0;
  logic [RW-1:0] sb[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] d, input logic last);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    while (!bus.in_ready && n < 50) begin
      tick();
      n++;
    end
    check("in_handshake", bus.in_ready, 1);
    tick();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic expect_result();
    int n;
    logic [RW-1:0] exp;
    n = 0;
    bus.res_ready = 1'b1;
    while (!bus.res_valid && n < 100) begin
      tick();
      n++;
    end
    check("res_arrive", bus.res_valid, 1);
    if (sb.size() == 0) begin
      check("sb_underflow", sb.size(), 1);
    end else begin
      exp = sb.pop_front();
      check("res_data", bus.res_data, exp);
    end
    tick();
    bus.res_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int            idx;
    int            acc_n;
    int            results;
    int            cyc;
    logic          acc;
    logic          prev_en;
    logic [RW-1:0] model_sum;
    logic [DW-1:0] val;
    logic [RW-1:0] exp;

    rst = 1'b1;
    seq_mode = 1'b0;
    done_inject = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.in_last = 1'b0;
    bus.res_ready = 1'b0;
    repeat (3) tick();

    check("rst_list_data", list_data, 0);
    check("rst_sum_en", sum_en, 0);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_elem_count", elem_count, 0);
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_res_data", bus.res_data, 0);
    rst = 1'b0;
    #1;
    check("release_in_ready", bus.in_ready, 1);

    // Stray sum_done and res_ready in LOAD do nothing.
    done_inject = 1'b1;
    bus.res_ready = 1'b1;
    tick();
    done_inject = 1'b0;
    bus.res_ready = 1'b0;
    check("stray_res_valid", bus.res_valid, 0);
    check("stray_in_ready", bus.in_ready, 1);
    check("stray_sum_en", sum_en, 0);

    // Full list, combinational adder.
    send(8'd1, 1'b0);
    send(8'd2, 1'b0);
    send(8'd3, 1'b0);
    send(8'd4, 1'b0);
    sb.push_back(RW'(10));
    check("full_sum_en", sum_en, 1);
    check("full_list", list_data, 32'h04030201);
    check("full_count", elem_count, 4);
    check("full_in_ready", bus.in_ready, 0);
    tick();
    check("full_sum_en_1cyc", sum_en, 0);
    check("full_res_valid", bus.res_valid, 1);
    expect_result();
    check("rearm_in_ready", bus.in_ready, 1);
    check("rearm_count", elem_count, 0);
    check("rearm_list", list_data, 0);
    check("rearm_res_valid", bus.res_valid, 0);

    // Short list closed by in_last.
    send(8'd5, 1'b0);
    send(8'd7, 1'b1);
    sb.push_back(RW'(12));
    check("short_list", list_data, 32'h00000705);
    check("short_count", elem_count, 2);
    check("short_sum_en", sum_en, 1);
    expect_result();
    check("short_next_count", elem_count, 0);
    check("short_next_list", list_data, 0);

    // Sequential adder, maximum elements, input pulses during SUM, result backpressure.
    seq_mode = 1'b1;
    repeat (4) send(8'd255, 1'b0);
    sb.push_back(RW'(1020));
    check("seq_sum_en", sum_en, 1);
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data = 8'h11;
      tick();
      check("seq_sum_en_hold", sum_en, 1);
      check("seq_in_ready", bus.in_ready, 0);
      check("seq_count", elem_count, 4);
    end
    bus.in_valid = 1'b0;
    tick();
    check("seq_sum_en_drop", sum_en, 0);
    check("seq_res_valid", bus.res_valid, 1);
    check("seq_res_data", bus.res_data, 1020);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_res_valid", bus.res_valid, 1);
      check("bp_res_data", bus.res_data, 1020);
      check("bp_in_ready", bus.in_ready, 0);
    end
    expect_result();
    check("bp_in_ready_after", bus.in_ready, 1);
    check("bp_list", list_data, 0);

    // Reset in the middle of SUM drops the list.
    send(8'd1, 1'b0);
    send(8'd2, 1'b1);
    check("mid_sum_en", sum_en, 1);
    tick();
    check("mid_sum_en_hold", sum_en, 1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_sum_en", sum_en, 0);
    check("mid_rst_list", list_data, 0);
    check("mid_rst_count", elem_count, 0);
    check("mid_rst_res_valid", bus.res_valid, 0);
    check("mid_rst_in_ready", bus.in_ready, 0);
    tick();
    rst = 1'b0;
    #1;
    check("mid_release_in_ready", bus.in_ready, 1);
    send(8'd9, 1'b1);
    sb.push_back(RW'(9));
    check("mid_fresh_list", list_data, 32'h00000009);
    expect_result();

    // Back-to-back lists with in_valid and res_ready held high.
    seq_mode = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_last = 1'b0;
    bus.res_ready = 1'b1;
    idx = 0;
    acc_n = 0;
    results = 0;
    cyc = 0;
    prev_en = sum_en;
    model_sum = '0;
    while (results < 3 && cyc < 300) begin
      val = DW'(20 + idx * 3);
      bus.in_data = val;
      acc = bus.in_ready;
      if (bus.res_valid) begin
        if (sb.size() == 0) begin
          check("b2b_sb_underflow", sb.size(), 1);
        end else begin
          exp = sb.pop_front();
          check("b2b_res_data", bus.res_data, exp);
        end
        results++;
      end
      tick();
      cyc++;
      if (acc) begin
        model_sum = model_sum + RW'(val);
        acc_n++;
        idx++;
        if (acc_n == LEN) begin
          sb.push_back(model_sum);
          model_sum = '0;
          acc_n = 0;
        end
      end
      if (sum_en) begin
        check("b2b_sum_en_gap", prev_en, 0);
        check("b2b_accepts", elem_count, LEN);
      end
      prev_en = sum_en;
    end
    bus.in_valid = 1'b0;
    bus.res_ready = 1'b0;
    check("b2b_results", results, 3);
    check("b2b_partial_accepts", acc_n, 0);
    check("sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/list_feeder.md
Name: list_feeder

Overview:
- Initiator/front end for the list `adder` block.
- Collects a stream of elements over a valid/ready handshake into the packed LENGTH*DATA_WIDTH list vector.
- Drives `sum_en` and holds the list stable until `sum_done`.
- Captures `sum_result` and returns it on a valid/ready result port, then rearms for the next list.

Parameters:
- DATA_WIDTH, 32, element width in bits.
- LENGTH, 8, elements per list; need not be a power of 2.
- RESULT_WIDTH, $clog2(LENGTH)+DATA_WIDTH (localparam), width of the sum result.
- CNT_WIDTH, $clog2(LENGTH+1) (localparam), width of the element counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  input element valid.
- in_data  in  DATA_WIDTH  input element.
- in_last  in  1  element is the last of a short list.
- in_ready  out  1  feeder accepts an element this cycle.
- list_data  out  LENGTH*DATA_WIDTH  packed list; element k at [k*DATA_WIDTH +: DATA_WIDTH]; connects to adder data_in.
- sum_en  out  1  connects to adder sum_en.
- sum_done  in  1  from adder.
- sum_result  in  RESULT_WIDTH  from adder.
- elem_count  out  CNT_WIDTH  elements loaded in the current list.
- res_valid  out  1  result valid.
- res_data  out  RESULT_WIDTH  captured sum.
- res_ready  in  1  downstream accepts the result.

Behaviour:
- Reset values: list_data=0, sum_en=0, in_ready=0, elem_count=0, res_valid=0, res_data=0; FSM=LOAD. in_ready rises in the first cycle after reset release, since it is combinational from state.
- FSM states: LOAD, SUM, RESULT. All outputs are registered except in_ready, which is 1 only in LOAD.
- LOAD:
  - Handshake: accept when in_valid && in_ready.
  - On accept: write in_data into slot elem_count; elem_count += 1.
  - Go to SUM on the accept where in_last=1 or elem_count==LENGTH-1.
  - Unwritten slots stay 0 (zero-fill for short lists).
- SUM:
  - sum_en=1 from the cycle after the closing accept; list_data is frozen.
  - At each clk edge with sum_done=1: res_data<=sum_result, res_valid<=1, sum_en<=0, go to RESULT.
  - This works for a combinational adder (sum_done=sum_en, so sum_en is high exactly 1 cycle) and for sequential/tree adders (wait N cycles).
  - Unbounded wait; no timeout.
- RESULT:
  - res_valid held with res_data stable until res_ready.
  - On res_valid && res_ready: res_valid<=0, list_data<=0, elem_count<=0, go to LOAD.
  - sum_en is guaranteed low for ≥1 cycle between lists, which clears adder internal state.
- Latency: closing accept → sum_en high next cycle; sum_done sampled → res_valid next cycle; res handshake → in_ready next cycle.
- Widths: RESULT_WIDTH passed through unmodified; no truncation in the feeder.
- Boundary conditions:
  - in_last on first element: list = {0,...,0,e0}.
  - Full list (LENGTH accepts) without in_last closes automatically. A later in_last belongs to the next list and closes it as normal.
  - in_last on the LENGTH-th element: same as auto-close, with no extra empty list.
  - in_valid outside LOAD: ignored, in_ready=0, no data loss.
  - sum_done high in LOAD or RESULT: ignored.
  - res_ready high with res_valid low: no effect.
  - Reset mid-operation (any state): immediate return to reset values. The partial list is discarded; a pending result is dropped.
- No simultaneous load and result; single list in flight.

Decomposition:
- Shared package list_pkg:
  - state enum (LOAD, SUM, RESULT).
  - function for result width ($clog2(n)+w), shared with adder users.
- No sub-module; one FSM plus slot register array. The bench instantiates list_feeder → adder for integration.

Test Plan:
- DATA_WIDTH=8, LENGTH=4, combinational adder: stream 1,2,3,4 with no in_last → list_data=0x04030201, sum_en high 1 cycle, res_data=10, res_valid until res_ready.
- Short list: 5 then 7 with in_last on 7 → list_data=0x00000705, elem_count=2, res_data=12; next list starts with elem_count=0 and list_data=0.
- Sequential adder, stream 255,255,255,255 → sum_en held high until sum_done (about 4 cycles), res_data=1020 (10 bits, no overflow); in_valid pulses during SUM not accepted.
- Backpressure: res_ready low for 5 cycles → res_valid and res_data stable, in_ready=0 throughout; in_ready rises the cycle after the res handshake.
- Reset asserted mid-SUM with sum_en=1 → sum_en, list_data, elem_count and res_valid all 0 immediately; after release a fresh list 9 with in_last → res_data=9.
- Back-to-back lists with in_valid constantly high and res_ready=1 → each list gets exactly 4 accepts, sum_en has ≥1 low cycle between lists, and results match the per-list reference sums.
